// File: rtl/mem_write_checker_if.sv
// Data-memory write port seen by mem_write_checker.
// The processor side drives it through the master modport and the checker observes it through the slave modport.
interface mem_write_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_write;
  logic [AW-1:0] data_adr;
  logic [DW-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker.sv
// End-of-program checker for the processor data-memory write port.
// It watches for NUM_CHECKS expected (address, data) stores, which can be required in index order
// (ORDERED=1) or accepted in any order (ORDERED=0).
// It reports a sticky PASS, FAIL or TIMEOUT status and keeps a cycle counter for the RUN period.
//
// Optional build macro MWC_STRICT_ADDR_EN:
//   defined   - a store to an address outside every EXP_ADDR entry is a FAIL.
//   undefined - such stores are ignored, so the program can use scratch memory.
module mem_write_checker #(
  parameter int                     AW         = 32,
  parameter int                     DW         = 32,
  parameter int                     NUM_CHECKS = 2,
  parameter logic [NUM_CHECKS*AW-1:0] EXP_ADDR = {32'h60, 32'h64},
  parameter logic [NUM_CHECKS*DW-1:0] EXP_DATA = {32'd25, 32'd7},
  parameter int                     ORDERED    = 1,
  parameter int                     CNT_W      = 8,
  parameter int                     TIMEOUT    = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  mem_write_checker_if.slave                bus,
  output logic [CNT_W-1:0]                  cycle_count,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   match_count,
  output logic [2:0]                        state,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic [AW-1:0]                     fail_adr,
  output logic [DW-1:0]                     fail_data
);

  localparam int               MCW        = $clog2(NUM_CHECKS + 1);
  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MCW-1:0]   MATCH_LAST = MCW'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic [CNT_W-1:0]        cycle_q,     cycle_d;
  logic [MCW-1:0]          match_q,     match_d;
  logic [NUM_CHECKS-1:0]   hit_q,       hit_d;
  logic [AW-1:0]           fail_adr_q,  fail_adr_d;
  logic [DW-1:0]           fail_data_q, fail_data_d;
  logic                    done_q,      done_d;
  logic                    pass_q,      pass_d;
  logic                    fail_q,      fail_d;

  // Per-entry compare results for the write on the bus this cycle
  logic [NUM_CHECKS-1:0]   addr_eq;
  logic [NUM_CHECKS-1:0]   data_eq;
  logic [NUM_CHECKS-1:0]   cand;
  logic [NUM_CHECKS-1:0]   full_hit;
  logic [NUM_CHECKS-1:0]   pick;
  logic                    found;
  logic                    active;
  logic                    go_match;
  logic                    go_fail;

  // Compare the bus write against every expected entry and choose which entries are still eligible
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, otherwise a path that skips an assignment infers a latch.
    addr_eq = '0;
    data_eq = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      addr_eq[i] = (bus.data_adr   == EXP_ADDR[i*AW +: AW]);
      data_eq[i] = (bus.write_data == EXP_DATA[i*DW +: DW]);
      if (ORDERED != 0) begin
        // Only the next entry in sequence can be checked.
        cand[i] = (MCW'(i) == match_q);
      end else begin
        // Any entry that is not yet matched can be checked.
        cand[i] = !hit_q[i];
      end
    end
    full_hit = cand & addr_eq & data_eq;
  end

  // Lowest-index full match; in ordered mode at most one bit can be set
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (full_hit[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Decide match or fail for this edge; IDLE with en=1 evaluates like RUN, so the starting edge is checked
  always_comb begin
    active   = en && (state_q == ST_IDLE || state_q == ST_RUN);
    go_match = 1'b0;
    go_fail  = 1'b0;
    if (active && bus.mem_write) begin
      go_match = found;
      // The address belongs to an eligible entry but the data is wrong.
      go_fail  = !found && |(cand & addr_eq);
`ifdef MWC_STRICT_ADDR_EN
      // A store to an address that no entry lists.
      if (~|addr_eq) begin
        go_fail = 1'b1;
      end
`endif
    end
  end

  // Next-state and next-output logic; on the same edge FAIL wins over PASS, and PASS wins over TIMEOUT
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    match_d     = match_q;
    hit_d       = hit_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;

    if (active) begin
      // The counter stops at TIMEOUT-1 and never wraps, because TIMEOUT or a terminal state always comes first.
      if (cycle_q != CYCLE_LAST) begin
        cycle_d = cycle_q + CNT_W'(1);
      end

      if (go_fail) begin
        state_d     = ST_FAIL;
        fail_adr_d  = bus.data_adr;
        fail_data_d = bus.write_data;
      end else begin
        if (go_match) begin
          match_d = match_q + MCW'(1);
          hit_d   = hit_q | pick;
        end
        if (go_match && match_q == MATCH_LAST) begin
          state_d = ST_PASS;
        end else if (cycle_q == CYCLE_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
    end

    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
  end

  // State, counters, hit mask, failure capture and status flags, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the hit mask is a small register array, so it is reset with everything else and a run never starts with stale hits.
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      match_q     <= '0;
      hit_q       <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples values from before the edge.
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      match_q     <= match_d;
      hit_q       <= hit_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign match_count = match_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker.
// It runs an ordered instance and an unordered instance side by side on one write bus.
// A reference model follows the matching rules on plain arrays.
// The bench uses directed scenarios first, then randomized runs.
module tb_mem_write_checker;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int N   = 2;
  localparam int TMO = 24;

  logic clk = 1'b0;
  logic reset;
  logic en;

  always #5 clk = ~clk;

  mem_write_checker_if #(.AW(AW), .DW(DW)) bus ();

  logic [7:0]  o_cycle, u_cycle;
  logic [1:0]  o_match, u_match;
  logic [2:0]  o_state, u_state;
  logic        o_done, u_done, o_pass, u_pass, o_fail, u_fail;
  logic [31:0] o_fadr, u_fadr, o_fdata, u_fdata;

  mem_write_checker #(.ORDERED(1)) dut_ord (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .cycle_count(o_cycle), .match_count(o_match), .state(o_state),
    .done(o_done), .pass(o_pass), .fail(o_fail),
    .fail_adr(o_fadr), .fail_data(o_fdata)
  );

  mem_write_checker #(.ORDERED(0)) dut_unord (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .cycle_count(u_cycle), .match_count(u_match), .state(u_state),
    .done(u_done), .pass(u_pass), .fail(u_fail),
    .fail_adr(u_fadr), .fail_data(u_fdata)
  );

  int tests = 0;
  int fails = 0;

  // Expected writes in index order: entry 0 is (0x64,7) and entry 1 is (0x60,25).
  int unsigned exp_adr  [N] = '{32'h64, 32'h60};
  int unsigned exp_data [N] = '{7, 25};

  // Model state, with index 0 for the ordered instance and index 1 for the unordered one.
  // Status codes: 0 idle, 1 run, 2 pass, 3 fail, 4 timeout.
  int          m_state [2];
  int          m_cycle [2];
  int          m_match [2];
  bit          m_hit   [2][N];
  int unsigned m_fadr  [2];
  int unsigned m_fdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 2; o++) begin
      m_state[o] = 0;
      m_cycle[o] = 0;
      m_match[o] = 0;
      m_fadr[o]  = 0;
      m_fdata[o] = 0;
      for (int i = 0; i < N; i++) m_hit[o][i] = 1'b0;
    end
  endtask

  // One clock edge of the model, applying the checking rules directly
  task automatic model_edge(input bit e, input bit we, input int unsigned a, input int unsigned d);
    for (int o = 0; o < 2; o++) begin
      bit good = 1'b0;
      bit bad  = 1'b0;
      int idx  = -1;
      if ((m_state[o] == 0 || m_state[o] == 1) && e) begin
        if (we) begin
          if (o == 0) begin
            if (a == exp_adr[m_match[o]]) begin
              if (d == exp_data[m_match[o]]) good = 1'b1;
              else bad = 1'b1;
            end
          end else begin
            for (int i = 0; i < N; i++)
              if (idx < 0 && !m_hit[o][i] && a == exp_adr[i] && d == exp_data[i]) idx = i;
            if (idx >= 0) good = 1'b1;
            else
              for (int i = 0; i < N; i++)
                if (!m_hit[o][i] && a == exp_adr[i]) bad = 1'b1;
          end
`ifdef MWC_STRICT_ADDR_EN
          begin
            bit listed = 1'b0;
            for (int i = 0; i < N; i++) if (a == exp_adr[i]) listed = 1'b1;
            if (!listed) bad = 1'b1;
          end
`endif
        end
        if (bad) begin
          m_state[o] = 3;
          m_fadr[o]  = a;
          m_fdata[o] = d;
        end else if (good && m_match[o] + 1 == N) begin
          m_state[o] = 2;
        end else if (m_cycle[o] == TMO - 1) begin
          m_state[o] = 4;
        end else begin
          m_state[o] = 1;
        end
        if (good && !bad) begin
          if (o == 0) m_hit[o][m_match[o]] = 1'b1;
          else        m_hit[o][idx] = 1'b1;
          m_match[o]++;
        end
        if (m_cycle[o] < TMO - 1) m_cycle[o]++;
      end
    end
  endtask

  task automatic check_one(input string who, input int o, input logic [2:0] st,
                           input logic [7:0] cc, input logic [1:0] mc, input logic dn,
                           input logic ps, input logic fl, input logic [31:0] fa,
                           input logic [31:0] fd);
    check({who, ".state"},     32'(st), 32'(m_state[o]));
    check({who, ".cycle"},     32'(cc), 32'(m_cycle[o]));
    check({who, ".match"},     32'(mc), 32'(m_match[o]));
    check({who, ".done"},      32'(dn), 32'(m_state[o] >= 2));
    check({who, ".pass"},      32'(ps), 32'(m_state[o] == 2));
    check({who, ".fail"},      32'(fl), 32'(m_state[o] == 3 || m_state[o] == 4));
    check({who, ".fail_adr"},  fa, m_fadr[o]);
    check({who, ".fail_data"}, fd, m_fdata[o]);
  endtask

  task automatic check_all();
    check_one("ord",   0, o_state, o_cycle, o_match, o_done, o_pass, o_fail, o_fadr, o_fdata);
    check_one("unord", 1, u_state, u_cycle, u_match, u_done, u_pass, u_fail, u_fadr, u_fdata);
  endtask

  // Called at a negedge: apply reset asynchronously, check it at once, then release
  task automatic do_reset();
    reset         = 1'b1;
    en            = 1'b0;
    bus.mem_write = 1'b0;
    model_reset();
    #1;
    check_all();
    check("reset.state_const", 32'(o_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of inputs, let the edge happen, check at the next negedge
  task automatic step(input bit e, input bit we, input int unsigned a, input int unsigned d);
    en             = e;
    bus.mem_write  = we;
    bus.data_adr   = a;
    bus.write_data = d;
    model_edge(e, we, a, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    reset          = 1'b1;
    en             = 1'b0;
    bus.mem_write  = 1'b0;
    bus.data_adr   = '0;
    bus.write_data = '0;
    @(negedge clk);

    // Basic ordered pass: (0x64,7) at cycle 3, then (0x60,25) at cycle 6.
    do_reset();
    idle_steps(3);
    step(1, 1, 32'h64, 7);
    check("basic.match1", 32'(o_match), 32'd1);
    idle_steps(2);
    step(1, 1, 32'h60, 25);
    idle_steps(3);
    check("basic.state", 32'(o_state), 32'd2);
    check("basic.pass",  32'(o_pass),  32'd1);
    check("basic.cycle", 32'(o_cycle), 32'd7);

    // Order violation: the ordered instance times out and the unordered one passes.
    do_reset();
    step(1, 1, 32'h60, 25);
    step(1, 1, 32'h64, 7);
    idle_steps(25);
    check("order.ord_state",   32'(o_state), 32'd4);
    check("order.ord_fail",    32'(o_fail),  32'd1);
    check("order.unord_pass",  32'(u_pass),  32'd1);

    // Data mismatch, then a correct store that must not change the status.
    do_reset();
    step(1, 1, 32'h64, 8);
    step(1, 1, 32'h64, 7);
    idle_steps(2);
    check("mismatch.state",     32'(o_state), 32'd3);
    check("mismatch.fail_adr",  o_fadr,       32'h64);
    check("mismatch.fail_data", o_fdata,      32'd8);
    check("mismatch.match",     32'(o_match), 32'd0);

    // Timeout with no writes.
    do_reset();
    idle_steps(27);
    check("timeout.state", 32'(o_state), 32'd4);
    check("timeout.cycle", 32'(o_cycle), 32'd23);

    // Final match on the timeout edge gives PASS.
    do_reset();
    idle_steps(2);
    step(1, 1, 32'h64, 7);
    idle_steps(20);
    step(1, 1, 32'h60, 25);
    check("tie.state", 32'(o_state), 32'd2);
    check("tie.cycle", 32'(o_cycle), 32'd23);

    // Pause: the counter holds and a store during the pause is ignored.
    do_reset();
    idle_steps(5);
    step(0, 0, 0, 0);
    step(0, 1, 32'h64, 7);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("pause.cycle", 32'(o_cycle), 32'd5);
    check("pause.match", 32'(o_match), 32'd0);
    step(1, 1, 32'h64, 7);
    step(1, 1, 32'h60, 25);
    check("pause.pass", 32'(o_pass), 32'd1);

    // Reset in the middle of a run.
    do_reset();
    idle_steps(2);
    step(1, 1, 32'h64, 7);
    do_reset();
    check("midreset.match", 32'(u_match), 32'd0);

    // A store to an unlisted address.
    step(1, 1, 32'h80, 1);
`ifdef MWC_STRICT_ADDR_EN
    check("strict.state",    32'(o_state), 32'd3);
    check("strict.fail_adr", o_fadr,       32'h80);
`else
    check("strict.state",    32'(o_state), 32'd1);
`endif

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int c = 0; c < 32; c++) begin
        bit          e  = ($urandom % 8) != 0;
        bit          we = ($urandom % 3) == 0;
        int unsigned a, d;
        case ($urandom % 6)
          0:       begin a = 32'h64; d = 7;                       end
          1:       begin a = 32'h60; d = 25;                      end
          2:       begin a = 32'h64; d = $urandom_range(0, 9);    end
          3:       begin a = 32'h60; d = $urandom_range(20, 27);  end
          4:       begin a = 32'h80; d = 1;                       end
          default: begin a = 32'h68; d = $urandom;                end
        endcase
        step(e, we, a, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
